// File: rtl/md4_block_loader_if.sv
// Stream-in / block-out handshake bundle for md4_block_loader.
// The loader binds to the slave modport; the upstream/downstream side uses master.
interface md4_block_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/md4_block_loader.sv
// Packs little-endian 32-bit message words into 512-bit MD4 blocks.
// Define MD4_PAD_EN to append the 0x80 pad byte and 64-bit bit-length field.
module md4_block_loader (
  input  logic                      clk,
  input  logic                      rst,
  md4_block_loader_if.slave         bus
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_e;

  state_e       state_q;
  logic [3:0]   w_q;
  logic [511:0] blk_q;
  logic         blk_last_q;

  logic [2:0]   nbytes;
  logic [31:0]  word_d;
  logic [511:0] blk_d;

`ifdef MD4_PAD_EN
  logic [60:0]  byte_cnt_q;
  logic         pend_extra_q;
  logic         pad64_q;
  logic [2:0]   eff_bytes;
  logic [6:0]   pad_pos;
  logic [60:0]  cnt_sum;
  logic [511:0] extra_d;
`endif

  assign bus.in_ready  = (state_q == FILL);
  assign bus.blk_valid = (state_q == EMIT);
  assign bus.blk_data  = blk_q;
  assign bus.blk_last  = blk_last_q;

  // Final-word byte count: anything outside 1..3 means a full word.
  always_comb begin
    unique case (bus.in_bytes)
      3'd1, 3'd2, 3'd3: nbytes = bus.in_bytes;
      default:          nbytes = 3'd4;
    endcase
  end

  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so later partial overrides can never infer a latch.
  always_comb begin
    word_d = bus.in_data;
    if (bus.in_last) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(nbytes)) word_d[8*k +: 8] = 8'h00;
      end
    end
    blk_d = blk_q;
    blk_d[{w_q, 5'b00000} +: 32] = word_d;
`ifdef MD4_PAD_EN
    eff_bytes = bus.in_last ? nbytes : 3'd4;
    pad_pos   = {1'b0, w_q, 2'b00} + {4'b0000, eff_bytes};
    cnt_sum   = byte_cnt_q + 61'(eff_bytes);
    if (bus.in_last) begin
      if (!pad_pos[6]) blk_d[{pad_pos[5:0], 3'b000} +: 8] = 8'h80;
      if (pad_pos <= 7'd55) blk_d[511:448] = {cnt_sum, 3'b000};
    end
    // Trailing length-only block; the pad byte lands here only when p hit 64.
    extra_d          = '0;
    extra_d[511:448] = {byte_cnt_q, 3'b000};
    if (pad64_q) extra_d[7:0] = 8'h80;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the block buffer is reset on purpose: a discarded partial
      // message must never leak into the next block's zero-filled tail.
      state_q    <= FILL;
      w_q        <= '0;
      blk_q      <= '0;
      blk_last_q <= 1'b0;
`ifdef MD4_PAD_EN
      byte_cnt_q   <= '0;
      pend_extra_q <= 1'b0;
      pad64_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            blk_q <= blk_d;
            w_q   <= w_q + 4'd1;
`ifdef MD4_PAD_EN
            byte_cnt_q <= cnt_sum;
`endif
            if (bus.in_last) begin
              state_q <= EMIT;
`ifdef MD4_PAD_EN
              blk_last_q   <= (pad_pos <= 7'd55);
              pend_extra_q <= (pad_pos > 7'd55);
              pad64_q      <= pad_pos[6];
`else
              blk_last_q <= 1'b1;
`endif
            end else if (w_q == 4'd15) begin
              state_q    <= EMIT;
              blk_last_q <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (bus.blk_ready) begin
            blk_q      <= '0;
            w_q        <= '0;
            blk_last_q <= 1'b0;
`ifdef MD4_PAD_EN
            if (blk_last_q) byte_cnt_q <= '0;
            pend_extra_q <= 1'b0;
            state_q      <= pend_extra_q ? EXTRA : FILL;
`else
            state_q <= FILL;
`endif
          end
        end
        EXTRA: begin
`ifdef MD4_PAD_EN
          blk_q      <= extra_d;
          blk_last_q <= 1'b1;
          pad64_q    <= 1'b0;
          state_q    <= EMIT;
`else
          state_q <= FILL;
`endif
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_block_loader.sv
// Directed bench for md4_block_loader; expectations follow the MD4_PAD_EN setting.
module tb_md4_block_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md4_block_loader_if bus ();

  md4_block_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [511:0] e;
  logic [511:0] e2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rep(input logic [31:0] v, input int n);
    logic [511:0] b = '0;
    for (int i = 0; i < n; i++) b[32*i +: 32] = v;
    return b;
  endfunction

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = b;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take(input string tag, input logic [511:0] ed, input logic el);
    int t = 0;
    while (bus.blk_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_timeout: blk_valid stayed %b, required 1", tag, bus.blk_valid);
    end
    chk({tag, "_data"}, bus.blk_data, ed);
    chk({tag, "_last"}, 512'(bus.blk_last), 512'(el));
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    bus.blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  512'(bus.in_ready),  512'(1));
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    chk("rst_blk_last",  512'(bus.blk_last),  512'(0));
    chk("rst_blk_data",  bus.blk_data, '0);

    // "abc" with 5 stalled cycles in EMIT.
    e = '0;
`ifdef MD4_PAD_EN
    e[31:0]    = 32'h80636261;
    e[479:448] = 32'h00000018;
`else
    e[31:0]    = 32'h00636261;
`endif
    send(32'h00636261, 1'b1, 3'd3);
    chk("abc_latency", 512'(bus.blk_valid), 512'(1));
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",  bus.blk_data, e);
      chk("stall_ready", 512'(bus.in_ready), 512'(0));
      chk("stall_valid", 512'(bus.blk_valid), 512'(1));
      @(negedge clk);
    end
    chk("abc_last", 512'(bus.blk_last), 512'(1));
    chk("abc_data", bus.blk_data, e);
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    chk("abc_ready_after", 512'(bus.in_ready), 512'(1));
    chk("abc_valid_after", 512'(bus.blk_valid), 512'(0));

    // Fourteen full words: pad byte lands at p=56 and forces a second block.
    for (int i = 0; i < 13; i++) send(32'h01010101, 1'b0, 3'd4);
    send(32'h01010101, 1'b1, 3'd4);
    e = rep(32'h01010101, 14);
`ifdef MD4_PAD_EN
    e[479:448] = 32'h00000080;
    take("m14_b1", e, 1'b0);
    chk("m14_extra_valid", 512'(bus.blk_valid), 512'(0));
    chk("m14_extra_ready", 512'(bus.in_ready), 512'(0));
    e = '0;
    e[479:448] = 32'h000001C0;
    take("m14_b2", e, 1'b1);
`else
    take("m14_b1", e, 1'b1);
`endif
    chk("m14_ready_after", 512'(bus.in_ready), 512'(1));

    // Sixteen full words, last one final: p=64.
    e = '0;
    for (int i = 0; i < 16; i++) begin
      send(32'hA5000000 | 32'(i), (i == 15), 3'd4);
      e[32*i +: 32] = 32'hA5000000 | 32'(i);
    end
`ifdef MD4_PAD_EN
    take("m16_b1", e, 1'b0);
    chk("m16_extra_valid", 512'(bus.blk_valid), 512'(0));
    e = '0;
    e[31:0]    = 32'h00000080;
    e[479:448] = 32'h00000200;
    take("m16_b2", e, 1'b1);
`else
    take("m16_b1", e, 1'b1);
    chk("m16_no_extra", 512'(bus.in_ready), 512'(1));
`endif

    // Sixteen non-final words, then a 2-byte final word in a new block.
    e = '0;
    for (int i = 0; i < 16; i++) begin
      send(32'h5A000000 | 32'(i), 1'b0, 3'd4);
      e[32*i +: 32] = 32'h5A000000 | 32'(i);
    end
    take("m17_b1", e, 1'b0);
    send(32'hAABBCCDD, 1'b1, 3'd2);
    e2 = '0;
`ifdef MD4_PAD_EN
    e2[31:0]    = 32'h0080CCDD;
    e2[479:448] = 32'h00000210;
`else
    e2[31:0]    = 32'h0000CCDD;
`endif
    take("m17_b2", e2, 1'b1);

    // p=55 boundary: last word at slot 13 with 3 bytes still fits the length.
    for (int i = 0; i < 13; i++) send(32'h01010101, 1'b0, 3'd4);
    send(32'h04030201, 1'b1, 3'd3);
    e = rep(32'h01010101, 13);
`ifdef MD4_PAD_EN
    e[447:416] = 32'h80030201;
    e[479:448] = 32'h000001B8;
`else
    e[447:416] = 32'h00030201;
`endif
    take("p55", e, 1'b1);

    // Reset after seven words: nothing emitted, then "abc" from slot 0.
    for (int i = 0; i < 7; i++) send(32'hDEADBEEF, 1'b0, 3'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rstfill_valid", 512'(bus.blk_valid), 512'(0));
      chk("rstfill_ready", 512'(bus.in_ready), 512'(1));
      @(negedge clk);
    end
    send(32'h00636261, 1'b1, 3'd3);
    e = '0;
`ifdef MD4_PAD_EN
    e[31:0]    = 32'h80636261;
    e[479:448] = 32'h00000018;
`else
    e[31:0]    = 32'h00636261;
`endif
    take("rstfill_abc", e, 1'b1);

    // Reset while a block is waiting in EMIT.
    send(32'h11223344, 1'b1, 3'd4);
    chk("rstemit_pre", 512'(bus.blk_valid), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstemit_valid", 512'(bus.blk_valid), 512'(0));
    chk("rstemit_data",  bus.blk_data, '0);
    chk("rstemit_last",  512'(bus.blk_last), 512'(0));
    chk("rstemit_ready", 512'(bus.in_ready), 512'(1));

    // in_bytes encodings: 0 and 7 mean 4; 1 and 2 mask the upper bytes.
    e = '0;
    e[31:0] = 32'h04030201;
`ifdef MD4_PAD_EN
    e[63:32]   = 32'h00000080;
    e[479:448] = 32'h00000020;
`endif
    send(32'h04030201, 1'b1, 3'd0);
    take("bytes0", e, 1'b1);
    send(32'h04030201, 1'b1, 3'd7);
    take("bytes7", e, 1'b1);

    e = '0;
    e[31:0] = 32'h44332211;
`ifdef MD4_PAD_EN
    e[63:32]   = 32'h000080AA;
    e[479:448] = 32'h00000028;
`else
    e[63:32]   = 32'h000000AA;
`endif
    send(32'h44332211, 1'b0, 3'd4);
    send(32'hDDCCBBAA, 1'b1, 3'd1);
    take("bytes1", e, 1'b1);

    e = '0;
`ifdef MD4_PAD_EN
    e[31:0]    = 32'h00800201;
    e[479:448] = 32'h00000010;
`else
    e[31:0]    = 32'h00000201;
`endif
    send(32'h04030201, 1'b1, 3'd2);
    take("bytes2", e, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
